uart_char_transmit: RTL and testbench
=====================================

// Module: uart_char_transmit
// PURPOSE
//  Transmit-side counterpart of the chat link's serial receiver: serializes one character
//  per request onto an idle-high UART line, 8N1 framing, LSB first. Sits between the local
//  keyboard/character buffer and the FPGA serial output pin. Reports busy while a frame is
//  in flight and pulses charSent when the stop bit completes.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit (>=2); sets baud = f_clk / CLKS_PER_BIT
//  DATA_BITS     8   data bits per character (1..8)
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  rst        in   1          synchronous reset, active-high
//  txData     in   DATA_BITS  character to send; sampled only on accepted txLoad
//  txLoad     in   1          request to send txData; accepted when txBusy==0
//  serialOut  out  1          UART line; idle high
//  txBusy     out  1          1 from cycle after acceptance until end of stop bit
//  charSent   out  1          one-cycle pulse on the final cycle of the stop bit
// BEHAVIOUR
//  Reset (rst==1 at posedge): state=IDLE, serialOut=1, txBusy=0, charSent=0, bit/baud
//   counters=0, shift register=0. Reset mid-frame aborts immediately; line returns high
//   next cycle; no charSent pulse for the aborted frame.
//  States: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE : serialOut=1. On txLoad && !txBusy: latch txData into shift reg, clear baud
//          counter, go START. txLoad while busy is ignored (not queued).
//   START: serialOut=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
//   DATA : serialOut=shift[0]; every CLKS_PER_BIT cycles shift right one, bit index+1;
//          after DATA_BITS bits go STOP.
//   STOP : serialOut=1 for CLKS_PER_BIT cycles; on last cycle charSent=1; then IDLE.
//  Latency: accept edge T -> serialOut falls at T+1 (registered output, no glitches).
//  Frame length: start edge to end of stop = (DATA_BITS+2)*CLKS_PER_BIT cycles exactly.
//  txBusy: registered; =1 in START/DATA/STOP, =0 in IDLE. Falls on the same edge that
//   returns state to IDLE (i.e. the cycle after charSent).
//  Back-to-back: txLoad held high with new txData in the cycle txBusy first reads 0 is
//   accepted; next start bit begins the following cycle, giving exactly one idle-high
//   cycle minimum between frames (stop bit is never shortened).
//  Baud counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); wraps to 0 at each
//   bit boundary. Bit index width $clog2(DATA_BITS+1); never exceeds DATA_BITS.
//  txData changes after acceptance have no effect on the frame in flight.
//  charSent and txBusy never both 0 while state!=IDLE; charSent only asserted in STOP.
// TESTING
//  1 Reset: hold rst 3 cycles with txLoad=1 -> serialOut=1, txBusy=0, charSent=0 throughout.
//  2 CLKS_PER_BIT=4, send 0x55 -> line 0,1,0,1,0,1,0,1,0,1 each 4 cycles, charSent pulses
//    once at cycle 40 after start edge, txBusy high for 40 cycles.
//  3 Send 0xA3 then hold txLoad with 0x0F -> second start bit begins exactly one idle cycle
//    after first frame's stop; receiver model decodes 0xA3, 0x0F.
//  4 Pulse txLoad with 0xFF while busy mid-frame -> ignored; only original byte sent,
//    single charSent.
//  5 Assert rst during DATA bit 3 of 0x00 -> serialOut=1 next cycle, no charSent, next
//    txLoad of 0x81 sends a clean full frame.
//  6 Change txData every cycle during a 0x3C frame -> line still carries 0x3C.

Source files
------------

// File: rtl/uart_char_transmit.sv
// UART character transmitter.
// Sends one character per accepted request as an 8N1-style frame, LSB first, on an
// idle-high line. The FSM and all outputs share one register stage, so txBusy,
// serialOut and charSent change on the same edge as the state.
// When an edge accepts a request, that same edge also drives the start bit.
// The line is never glitched by combinational decode.

module uart_char_transmit #(
    parameter int unsigned CLKS_PER_BIT = 16,  // clk cycles per serial bit, >= 2
    parameter int unsigned DATA_BITS    = 8    // data bits per character, 1..8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] txData,
    input  logic                 txLoad,
    output logic                 serialOut,
    output logic                 txBusy,
    output logic                 charSent
);

    // Counter widths.
    // The baud counter runs 0..CLKS_PER_BIT-1.
    // The bit index runs 0..DATA_BITS.
    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW  = $clog2(DATA_BITS + 1);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    // charSent is registered.
    // It is therefore armed one cycle early, so that it is high during the final stop cycle.
    localparam logic [BaudW-1:0] BaudPenult = BaudW'(CLKS_PER_BIT - 2);
    localparam logic [IdxW-1:0]  IdxLast    = IdxW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e               r_state;
    logic [BaudW-1:0]     r_baud;
    logic [IdxW-1:0]      r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_serial;
    logic                 r_busy;
    logic                 r_sent;

    logic                 w_accept;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_shift_next;

    // A request is taken only while idle.
    // A request that arrives while busy is dropped, not queued.
    assign w_accept     = txLoad && !r_busy;
    assign w_bit_end    = (r_baud == BaudLast);
    assign w_shift_next = r_shift >> 1;

    // Frame sequencer.
    // The state, the counters, the shift register and the registered line outputs are updated together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_serial  <= 1'b1;
            r_busy    <= 1'b0;
            r_sent    <= 1'b0;
        end else begin
            // charSent is a single-cycle pulse.
            // The stop-bit branch is the only place that raises it.
            r_sent <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                    r_baud   <= '0;
                    if (w_accept) begin
                        // Capture the character now.
                        // Later changes on txData cannot disturb the frame.
                        r_shift   <= txData;
                        r_bit_idx <= '0;
                        r_serial  <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= StStart;
                    end
                end

                StStart: begin
                    if (w_bit_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_serial  <= r_shift[0];
                        r_state   <= StData;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                StData: begin
                    if (w_bit_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= r_bit_idx + 1'b1;
                        r_shift   <= w_shift_next;
                        if (r_bit_idx == IdxLast) begin
                            r_serial <= 1'b1;
                            r_state  <= StStop;
                        end else begin
                            r_serial <= w_shift_next[0];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                StStop: begin
                    if (w_bit_end) begin
                        // The stop bit runs its full length before the FSM returns to idle.
                        // This leaves at least one idle-high cycle between frames.
                        r_baud  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                        if (r_baud == BaudPenult) begin
                            r_sent <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                    r_baud   <= '0;
                    r_state  <= StIdle;
                end
            endcase
        end
    end

    assign serialOut = r_serial;
    assign txBusy    = r_busy;
    assign charSent  = r_sent;

endmodule

// File: tb/tb_uart_char_transmit.sv
// Testbench for uart_char_transmit.
// Characters are pushed onto a scoreboard when the request is driven.
// A line-level receiver model checks every frame and pops the scoreboard at the stop bit.

module tb_uart_char_transmit;

    localparam int CPB   = 4;
    localparam int DB    = 8;
    localparam int FRAME = (DB + 2) * CPB;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic [DB-1:0] txData  = '0;
    logic          txLoad  = 1'b0;
    logic          serialOut;
    logic          txBusy;
    logic          charSent;

    int n_checks = 0;
    int n_errors = 0;

    logic [DB-1:0] exp_q[$];

    // Receiver model state
    int            frames_done  = 0;
    int            aborted      = 0;
    int            idle_gap     = 0;
    int            cyc          = 0;
    int            last_end     = -100;
    bit            in_frame     = 1'b0;
    bit            fall_pending = 1'b0;
    int            cnt          = 0;
    int            sent_cnt     = 0;
    int            busy_lo      = 0;
    int            line_err     = 0;
    logic [DB-1:0] rx           = '0;
    logic [DB-1:0] exp_cur      = '0;

    uart_char_transmit #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .txData    (txData),
        .txLoad    (txLoad),
        .serialOut (serialOut),
        .txBusy    (txBusy),
        .charSent  (charSent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request.
    // The task then checks that the start bit and txBusy appear right after the accepting edge.
    task automatic send(input logic [DB-1:0] d);
        txData = d;
        txLoad = 1'b1;
        exp_q.push_back(d);
        tick();
        txLoad = 1'b0;
        @(negedge clk);
        check("start_latency", 32'(serialOut), 32'd0);
        check("busy_rise", 32'(txBusy), 32'd1);
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 3 * FRAME && frames_done < target; i++) @(negedge clk);
        check("frames_done", 32'(frames_done), 32'(target));
    endtask

    // Receiver model.
    // It samples at the falling edge.
    // For each frame it checks the exact per-cycle line shape, mid-bit decode,
    // the charSent position and count, and the extent of txBusy.
    always @(negedge clk) begin
        logic       exp_line;
        logic [2:0] bidx;
        cyc++;
        if (fall_pending) begin
            fall_pending = 1'b0;
            check("busy_fall", 32'(txBusy), 32'd0);
        end
        if (rst) begin
            if (in_frame) begin
                in_frame = 1'b0;
                aborted++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end else if (!in_frame && serialOut === 1'b0) begin
            in_frame = 1'b1;
            cnt      = 0;
            sent_cnt = 0;
            busy_lo  = 0;
            line_err = 0;
            rx       = '0;
            exp_cur  = (exp_q.size() > 0) ? exp_q[0] : '0;
            idle_gap = cyc - last_end - 1;
        end else if (!in_frame && charSent !== 1'b0) begin
            check("sent_idle", 32'(charSent), 32'd0);
        end

        if (in_frame) begin
            if (charSent === 1'b1) sent_cnt++;
            if (txBusy !== 1'b1) busy_lo++;
            if (cnt < CPB) begin
                exp_line = 1'b0;
            end else if (cnt >= FRAME - CPB) begin
                exp_line = 1'b1;
            end else begin
                bidx     = 3'(cnt / CPB - 1);
                exp_line = exp_cur[bidx];
            end
            if (serialOut !== exp_line) line_err++;

            if (cnt == CPB / 2) begin
                check("start_bit", 32'(serialOut), 32'd0);
            end else if (cnt == FRAME - CPB + CPB / 2) begin
                check("stop_bit", 32'(serialOut), 32'd1);
            end else if (cnt > CPB && cnt < FRAME - CPB && (cnt % CPB) == CPB / 2) begin
                bidx     = 3'(cnt / CPB - 1);
                rx[bidx] = serialOut;
            end

            if (cnt == FRAME - 1) begin
                check("sent_last_cycle", 32'(charSent), 32'd1);
                check("sent_count", 32'(sent_cnt), 32'd1);
                check("busy_in_frame", 32'(busy_lo), 32'd0);
                check("line_shape", 32'(line_err), 32'd0);
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("rx_data", 32'(rx), 32'(exp_q.pop_front()));
                in_frame     = 1'b0;
                frames_done++;
                last_end     = cyc;
                fall_pending = 1'b1;
            end else begin
                cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with txLoad high: the line stays idle.
        rst    = 1'b1;
        txLoad = 1'b1;
        txData = 8'h55;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_line", 32'(serialOut), 32'd1);
            check("rst_busy", 32'(txBusy), 32'd0);
            check("rst_sent", 32'(charSent), 32'd0);
        end
        tick();
        rst    = 1'b0;
        txLoad = 1'b0;
        repeat (3) tick();

        // Alternating pattern, exact per-cycle shape.
        send(8'h55);
        wait_frames(1);

        // Back-to-back: the second request is held from the first acceptance onwards.
        tick();
        txData = 8'hA3;
        txLoad = 1'b1;
        exp_q.push_back(8'hA3);
        tick();
        txData = 8'h0F;
        exp_q.push_back(8'h0F);
        repeat (FRAME + 1) tick();
        txLoad = 1'b0;
        wait_frames(3);
        check("b2b_idle_gap", 32'(idle_gap), 32'd1);

        // A request made while busy is ignored.
        tick();
        send(8'h96);
        repeat (14) tick();
        txData = 8'hFF;
        txLoad = 1'b1;
        tick();
        txLoad = 1'b0;
        wait_frames(4);
        repeat (FRAME + 5) tick();
        check("busy_load_ignored", 32'(frames_done), 32'd4);

        // Reset in data bit 3 aborts the frame.
        send(8'h00);
        repeat (17) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_line", 32'(serialOut), 32'd1);
        check("abort_busy", 32'(txBusy), 32'd0);
        check("abort_sent", 32'(charSent), 32'd0);
        check("abort_seen", 32'(aborted), 32'd1);
        repeat (FRAME) tick();
        check("abort_no_frame", 32'(frames_done), 32'd4);
        send(8'h81);
        wait_frames(5);

        // Changes on txData during the frame must not reach the line.
        tick();
        send(8'h3C);
        for (int i = 0; i < FRAME + 4; i++) begin
            tick();
            txData = 8'($urandom);
        end
        wait_frames(6);

        repeat (4) tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
